// File: rtl/psum_collector.sv
// psum_collector: per-column partial-sum lanes with a shared read pointer.
// Skewed column writes are re-aligned and popped as whole rows.
module psum_collector #(
    parameter int col     = 8,
    parameter int bw_psum = 32,
    parameter int depth   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [col-1:0]         in_wr,
    input  logic [col*bw_psum-1:0] in_data,
    input  logic                   rd,
    output logic [col*bw_psum-1:0] out,
    output logic                   o_valid,
    output logic                   o_ready,
    output logic                   o_full,
    output logic                   overflow
);

    localparam int aw = $clog2(depth);
    localparam int cw = aw + 1;

    logic [bw_psum-1:0] mem [col][depth];
    logic [aw-1:0]      wptr [col];
    logic [cw-1:0]      cnt [col];
    logic [aw-1:0]      rptr;

    logic [col-1:0] lane_full;
    logic [col-1:0] lane_nz;
    logic [col-1:0] wr_ok;
    logic           pop;
    logic           drop;

    always_comb begin
        lane_full = '0;
        lane_nz   = '0;
        for (int c = 0; c < col; c++) begin
            lane_full[c] = (cnt[c] == cw'(depth));
            lane_nz[c]   = (cnt[c] != '0);
        end
    end

    assign o_ready = &lane_nz;
    assign o_full  = |lane_full;
    assign pop     = rd & o_ready;
    // A full lane can still take a write when the same edge pops a row.
    assign wr_ok   = in_wr & (~lane_full | {col{pop}});
    assign drop    = |(in_wr & ~wr_ok);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c]) begin
                    mem[c][wptr[c]] <= in_data[c*bw_psum +: bw_psum];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr     <= '0;
            out      <= '0;
            o_valid  <= 1'b0;
            overflow <= 1'b0;
            for (int c = 0; c < col; c++) begin
                wptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            o_valid <= pop;
            if (drop) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rptr <= rptr + aw'(1);
                for (int c = 0; c < col; c++) begin
                    out[c*bw_psum +: bw_psum] <= mem[c][rptr];
                end
            end
            for (int c = 0; c < col; c++) begin
                if (wr_ok[c]) begin
                    wptr[c] <= wptr[c] + aw'(1);
                end
                case ({wr_ok[c], pop})
                    2'b10:   cnt[c] <= cnt[c] + cw'(1);
                    2'b01:   cnt[c] <= cnt[c] - cw'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector with two 32-bit lanes, depth 8.
// Expected rows are hand-computed constants.
module tb_psum_collector;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  in_wr = '0;
    logic [63:0] in_data = '0;
    logic        rd = 1'b0;
    logic [63:0] out;
    logic        o_valid;
    logic        o_ready;
    logic        o_full;
    logic        overflow;

    int total = 0;
    int passed = 0;
    logic [63:0] held;

    psum_collector #(.col(2), .bw_psum(32), .depth(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_wr(in_wr),
        .in_data(in_data),
        .rd(rd),
        .out(out),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_full(o_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] row(input int a, input int b);
        return {32'(b), 32'(a)};
    endfunction

    initial begin
        // reset state
        step();
        step();
        chk("rst_out", out, 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_full", 64'(o_full), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // basic aligned write then pop
        reset = 1'b1;
        in_wr = 2'b11;
        in_data = row(1, 2);
        step();
        in_wr = 2'b00;
        chk("basic_ready", 64'(o_ready), 64'd1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("basic_out", out, row(1, 2));
        chk("basic_valid", 64'(o_valid), 64'd1);
        chk("basic_ready0", 64'(o_ready), 64'd0);
        step();
        chk("basic_pulse", 64'(o_valid), 64'd0);
        chk("basic_hold", out, row(1, 2));

        // skewed arrival
        in_wr = 2'b01;
        in_data = row(10, 0);
        step();
        chk("skew_ready_t1", 64'(o_ready), 64'd0);
        in_wr = 2'b10;
        in_data = row(0, 20);
        step();
        in_wr = 2'b00;
        chk("skew_ready_t2", 64'(o_ready), 64'd1);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("skew_out", out, row(10, 20));

        // fill, then a dropped 9th write
        for (int i = 0; i < 8; i++) begin
            in_wr = 2'b11;
            in_data = row(i, i + 256);
            step();
        end
        chk("fill_full", 64'(o_full), 64'd1);
        in_data = row(999, 999);
        step();
        in_wr = 2'b00;
        chk("drop_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 8; i++) begin
            rd = 1'b1;
            step();
            chk($sformatf("drain_%0d", i), out, row(i, i + 256));
        end
        rd = 1'b0;
        chk("drain_empty", 64'(o_ready), 64'd0);
        step();
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // 9th write with same-cycle pop on a full buffer
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_wr = 2'b11;
            in_data = row(i + 40, i + 80);
            step();
        end
        in_data = row(48, 88);
        rd = 1'b1;
        step();
        in_wr = 2'b00;
        chk("fullpop_out", out, row(40, 80));
        chk("fullpop_ovf", 64'(overflow), 64'd0);
        chk("fullpop_full", 64'(o_full), 64'd1);
        for (int i = 1; i < 9; i++) begin
            step();
            chk($sformatf("fullpop_drain_%0d", i), out, row(i + 40, i + 80));
        end
        rd = 1'b0;
        step();
        chk("fullpop_empty", 64'(o_ready), 64'd0);

        // wrap: many write/read pairs
        for (int i = 0; i < 20; i++) begin
            in_wr = 2'b11;
            in_data = row(100 + i, 200 + i);
            step();
            in_wr = 2'b00;
            rd = 1'b1;
            step();
            rd = 1'b0;
            chk($sformatf("wrap_%0d", i), out, row(100 + i, 200 + i));
        end

        // rd held while empty
        held = row(119, 219);
        rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("empty_valid_%0d", i), 64'(o_valid), 64'd0);
            chk($sformatf("empty_out_%0d", i), out, held);
        end
        rd = 1'b0;

        // reset mid-operation dominates writes and pops
        for (int i = 0; i < 3; i++) begin
            in_wr = 2'b11;
            in_data = row(60 + i, 70 + i);
            step();
        end
        reset = 1'b0;
        rd = 1'b1;
        step();
        chk("mrst_out", out, 64'd0);
        chk("mrst_valid", 64'(o_valid), 64'd0);
        chk("mrst_ready", 64'(o_ready), 64'd0);
        chk("mrst_full", 64'(o_full), 64'd0);
        reset = 1'b1;
        in_data = row(7, 7);
        step();
        in_wr = 2'b00;
        chk("wr_rd_empty_valid", 64'(o_valid), 64'd0);
        chk("wr_rd_empty_ready", 64'(o_ready), 64'd1);
        step();
        rd = 1'b0;
        chk("post_rst_out", out, row(7, 7));
        chk("post_rst_valid", 64'(o_valid), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter col, default 8: number of mac_col columns feeding the block.
REQ-002 Parameter bw_psum, default 32: partial-sum width per column.
REQ-003 Parameter depth, default 8: entries per column lane, power of two, at least 2.
REQ-004 Port clk  input  1: single clock, all state updates on rising edge.
REQ-005 Port reset  input  1: synchronous, active-low (0 = reset asserted), sampled on clk rising edge.
REQ-006 Port in_wr  input  col: per-column write strobe, bit c driven by column c fifo_wr.
REQ-007 Port in_data  input  col*bw_psum: per-column psum, lane c at bits [c*bw_psum +: bw_psum], driven by column c out.
REQ-008 Port rd  input  1: request to pop one aligned row, i.e. one entry from every lane.
REQ-009 Port out  output  col*bw_psum: registered popped row, same lane packing as in_data.
REQ-010 Port o_valid  output  1: one-cycle pulse, out holds a newly popped row.
REQ-011 Port o_ready  output  1: every lane holds at least one entry.
REQ-012 Port o_full  output  1: at least one lane holds depth entries.
REQ-013 Port overflow  output  1: sticky flag, a write was dropped.

Function
REQ-014 Each lane is an independent circular buffer with its own write pointer; lanes share one read pointer; occupancy counter per lane is log2(depth)+1 bits.
REQ-015 Write accepted on lane c when in_wr[c]=1 and the lane is not full, or the lane is full and a pop is accepted in the same cycle; data stored at the lane write pointer, which then increments.
REQ-016 Write to a full lane with no same-cycle pop is dropped; the entry is unchanged and overflow is set to 1 on the next edge.
REQ-017 Pop accepted when rd=1 and o_ready=1; the shared read pointer increments and every lane occupancy decrements, net of any same-cycle write on that lane.
REQ-018 rd=1 while o_ready=0 is ignored: no pointer, count, out or o_valid change.
REQ-019 Read latency is 1 cycle: an accepted pop at edge N loads out with the row at the old read pointer and sets o_valid=1 after edge N.
REQ-020 o_valid is 0 in any cycle after an edge with no accepted pop; out holds its last value.
REQ-021 Pointers wrap from depth-1 to 0 with no gap or duplicated entry.
REQ-022 A simultaneous write and pop on an empty lane is impossible because o_ready=0; the write is accepted and the pop is ignored.
REQ-023 o_ready and o_full are combinational from the lane occupancies and reflect the state after the last edge.
REQ-024 Lanes with in_wr=0 are untouched, so skewed column arrival (column c+1 one cycle after column c) aligns automatically into rows.
REQ-025 Data is stored and returned bit-exact with no arithmetic; values are opaque bw_psum-bit words.

Reset
REQ-026 While reset=0 at a clk edge: all pointers and occupancies go to 0, out=0, o_valid=0 and overflow=0; o_ready=0 and o_full=0 follow.
REQ-027 Reset dominates in_wr and rd in the same cycle; writes and pops presented during reset are discarded.
REQ-028 Reset mid-operation discards all stored entries; after reset deasserts, the first row read is the first row written.
REQ-029 overflow clears only on reset.

Verification
REQ-030 col=2. After reset, write lane0=1 and lane1=2 in the same cycle, then pulse rd -> one cycle later out={32'd2,32'd1}, o_valid=1 for 1 cycle, o_ready=0.
REQ-031 Skewed input: lane0 gets 10 at cycle t and lane1 gets 20 at t+1 -> o_ready=0 at t+1 and 1 at t+2; rd returns {20,10}.
REQ-032 Fill: write depth=8 rows 0..7 -> o_full=1; a 9th write without rd -> overflow=1 and reads return 0..7 in order; a 9th write with same-cycle rd -> accepted, overflow stays 0.
REQ-033 Wrap: 20 write/read iterations with values 100+i -> every popped row equals the written row, no loss.
REQ-034 Hold rd=1 with all lanes empty for 3 cycles -> o_valid stays 0 and out is unchanged.
REQ-035 Load 3 rows, assert reset=0 together with in_wr=all-ones and rd=1 -> outputs all 0, o_ready=0; after release, writing 7 and reading returns 7.
